vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 86 ++++++++
 tb/tb_vga_timing_gen.sv | 116 +++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, sync pulses, active-video flag,
// line/frame strobes and a wrapping frame counter, all advanced by pix_en.
module vga_timing_gen #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int HS_POL = 0,
    parameter int VS_POL = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] x_px,
    output logic [9:0] y_px,
    output logic       hsync,
    output logic       vsync,
    output logic       activevideo,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_ACT    = 10'(H_VIS);
    localparam logic [9:0] V_ACT    = 10'(V_VIS);
    localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic       HS_ON    = (HS_POL != 0);
    localparam logic       VS_ON    = (VS_POL != 0);

    logic       h_wrap;
    logic       v_wrap;
    logic [9:0] x_nxt;
    logic [9:0] y_nxt;

    always_comb begin
        h_wrap = (x_px == H_LAST);
        v_wrap = (y_px == V_LAST);
        x_nxt  = h_wrap ? 10'd0 : x_px + 10'd1;
        y_nxt  = y_px;
        if (h_wrap) begin
            y_nxt = v_wrap ? 10'd0 : y_px + 10'd1;
        end
    end

    // Flags are decoded from the next position so they land in the same cycle as it.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_px        <= 10'd0;
            y_px        <= 10'd0;
            hsync       <= !HS_ON;
            vsync       <= !VS_ON;
            activevideo <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame       <= 8'd0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                x_px        <= x_nxt;
                y_px        <= y_nxt;
                hsync       <= (x_nxt >= HS_FIRST && x_nxt <= HS_LAST) ? HS_ON : !HS_ON;
                vsync       <= (y_nxt >= VS_FIRST && y_nxt <= VS_LAST) ? VS_ON : !VS_ON;
                activevideo <= (x_nxt < H_ACT) && (y_nxt < V_ACT);
                line_start  <= h_wrap;
                frame_start <= h_wrap && v_wrap;
                if (h_wrap && v_wrap) begin
                    frame <= frame + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen using the small-raster parameter set, checked
// against a model that derives every output from the count of pixel advances since reset.
module tb_vga_timing_gen;

    localparam int H_VIS = 8, H_FP = 2, H_SYNC = 3, H_BP = 3;
    localparam int V_VIS = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
    localparam int HS_POL = 1, VS_POL = 1;
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int F_TOT = H_TOT * V_TOT;

    if (H_TOT > 1024 || V_TOT > 1024) begin : g_size_check
        $error("raster totals exceed 1024");
    end

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_en = 1'b1;
    logic [9:0] x_px, y_px;
    logic       hsync, vsync, activevideo, line_start, frame_start;
    logic [7:0] frame;

    int n_vec = 0;
    int n_err = 0;

    // model: number of advances since reset, and whether the last edge advanced
    int  adv_cnt = 0;
    bit  adv_last = 0;

    vga_timing_gen #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .x_px(x_px), .y_px(y_px), .hsync(hsync), .vsync(vsync),
        .activevideo(activevideo), .line_start(line_start),
        .frame_start(frame_start), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got %0d expected %0d (advances=%0d)", tag, got, exp, adv_cnt);
        end
    endtask

    task automatic check_outputs();
        int ex, ey, ef;
        bit hs_act, vs_act;
        ex = adv_cnt % H_TOT;
        ey = (adv_cnt / H_TOT) % V_TOT;
        ef = (adv_cnt / F_TOT) % 256;
        hs_act = (ex >= H_VIS + H_FP) && (ex < H_VIS + H_FP + H_SYNC);
        vs_act = (ey >= V_VIS + V_FP) && (ey < V_VIS + V_FP + V_SYNC);
        chk("x_px", int'(x_px), ex);
        chk("y_px", int'(y_px), ey);
        chk("frame", int'(frame), ef);
        chk("hsync", int'(hsync), hs_act ? HS_POL : 1 - HS_POL);
        chk("vsync", int'(vsync), vs_act ? VS_POL : 1 - VS_POL);
        chk("activevideo", int'(activevideo), int'(ex < H_VIS && ey < V_VIS));
        chk("line_start", int'(line_start), int'(adv_last && ex == 0));
        chk("frame_start", int'(frame_start), int'(adv_last && ex == 0 && ey == 0));
    endtask

    task automatic step(input bit rst, input bit en);
        reset  = rst;
        pix_en = en;
        @(posedge clk);
        if (rst) begin
            adv_cnt  = 0;
            adv_last = 0;
        end else begin
            adv_last = en;
            if (en) adv_cnt++;
        end
        #1;
        check_outputs();
    endtask

    initial begin
        // reset with pix_en held high
        repeat (3) step(1'b1, 1'b1);

        // two full frames, continuous advance
        repeat (2 * F_TOT) step(1'b0, 1'b1);

        // alternating enable: one advance per two clocks, single-cycle strobes
        for (int i = 0; i < 4 * H_TOT; i++) step(1'b0, (i % 2) == 0);

        // run far enough to wrap the 8-bit frame counter
        repeat (256 * F_TOT) step(1'b0, 1'b1);

        // reset in the middle of hsync and vsync
        for (int i = 0; i < 4 * F_TOT; i++) begin
            if ((adv_cnt % H_TOT) == H_VIS + H_FP + 1 &&
                ((adv_cnt / H_TOT) % V_TOT) == V_VIS + V_FP) break;
            step(1'b0, 1'b1);
        end
        chk("sync_reached", int'(hsync && vsync), 1);
        step(1'b1, 1'b1);
        repeat (2 * F_TOT) step(1'b0, 1'b1);

        // random enable with occasional reset
        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
